// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_pkg
// Purpose  : Shared types, defaults and helpers for the Maxnet sequencer:
//            state encoding, control-output bundle and its Moore decode.
// Revision : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

  localparam int c_DEF_N_NEURONS = 4;
  localparam int c_DEF_MUL_CYCLES = 1;
  localparam int c_DEF_ADD_CYCLES = 1;
  localparam int c_DEF_MAX_ITER = 15;

  // Explicit 3-bit encoding so the state value is stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_MUL    = 3'd2,
    ST_ADD    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Datapath control strobes, all registered in the sequencer.
  typedef struct packed {
    logic load_x;
    logic load_t;
    logic select_t;
    logic mul_en;
    logic add_en;
    logic busy;
    logic result_valid;
  } ctrl_t;

  // Width needed to hold 0..max_iter inclusive.
  function automatic int iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  // Moore decode of the control strobes for a given state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_INIT: begin
        c.load_x   = 1'b1;
        c.load_t   = 1'b1;
        c.select_t = 1'b1;
      end
      ST_MUL:    c.mul_en = 1'b1;
      ST_ADD:    c.add_en = 1'b1;
      ST_UPDATE: c.load_t = 1'b1;
      ST_DONE:   c.result_valid = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage : maxnet_pkg
`default_nettype wire

// File: rtl/maxnet_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_phase_cnt
// Purpose  : Loadable down-counter with clear. Loaded with (cycles-1) on
//            entry to a phase; o_last flags the final cycle of the phase.
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_phase_cnt #(
  parameter int MAX_CNT = 1,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Clear dominates load; load dominates count; count stops at zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == '0);

endmodule : maxnet_phase_cnt
`default_nettype wire

// File: rtl/maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_sequencer
// Purpose  : Control unit for the Maxnet winner-take-all datapath. Sequences
//            INIT/MUL/ADD/UPDATE iterations with multi-cycle MUL and ADD
//            phases, bounds the run by MAX_ITER and holds the result until
//            result_ack.
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_sequencer
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS  = c_DEF_N_NEURONS,
  parameter int MUL_CYCLES = c_DEF_MUL_CYCLES,
  parameter int ADD_CYCLES = c_DEF_ADD_CYCLES,
  parameter int MAX_ITER   = c_DEF_MAX_ITER,
  parameter int ITER_W     = iter_w(MAX_ITER)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done,
  input  logic [N_NEURONS-1:0] active_mask,
  input  logic                 result_ack,
  output logic                 load_x,
  output logic                 load_t,
  output logic                 select_t,
  output logic                 mul_en,
  output logic                 add_en,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 all_zero,
  output logic [ITER_W-1:0]    iter_cnt
);

  // One shared phase counter, sized for the longer of the two phases.
  localparam int PH_MAX = (MUL_CYCLES > ADD_CYCLES) ? MUL_CYCLES : ADD_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]   c_MUL_LAST   = PH_W'(MUL_CYCLES - 1);
  localparam logic [PH_W-1:0]   c_ADD_LAST   = PH_W'(ADD_CYCLES - 1);
  localparam logic [ITER_W-1:0] c_ITER_LIMIT = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] c_ITER_SAT   = ITER_W'(MAX_ITER);

  state_e            r_state;
  state_e            w_next;
  ctrl_t             r_ctrl;
  logic [ITER_W-1:0] r_iter;
  logic              r_timeout;
  logic              r_all_zero;
  logic              w_term_to;
  logic              w_term_az;

  logic              w_ph_clr;
  logic              w_ph_load;
  logic [PH_W-1:0]   w_ph_val;
  logic              w_ph_en;
  logic              w_ph_last;

  maxnet_phase_cnt #(
    .MAX_CNT (PH_MAX),
    .CNT_W   (PH_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_ph_clr),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .i_en       (w_ph_en),
    .o_last     (w_ph_last)
  );

  // Next-state selection with termination-cause priority in UPDATE.
  always_comb begin
    w_next    = r_state;
    w_term_to = 1'b0;
    w_term_az = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_INIT;
      ST_INIT: if (!start) w_next = ST_MUL;
      ST_MUL:  if (w_ph_last) w_next = ST_ADD;
      ST_ADD:  if (w_ph_last) w_next = ST_UPDATE;
      ST_UPDATE: begin
        if (done) begin
          w_next = ST_DONE;
        end else if (active_mask == '0) begin
          w_next    = ST_DONE;
          w_term_az = 1'b1;
        end else if (r_iter == c_ITER_LIMIT) begin
          w_next    = ST_DONE;
          w_term_to = 1'b1;
        end else begin
          w_next = ST_MUL;
        end
      end
      ST_DONE: if (result_ack) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Phase counter: loaded on entry to MUL or ADD, counts down while there.
  always_comb begin
    w_ph_clr  = (r_state == ST_IDLE);
    w_ph_load = ((w_next == ST_MUL) && (r_state != ST_MUL)) ||
                ((w_next == ST_ADD) && (r_state != ST_ADD));
    w_ph_val  = (w_next == ST_ADD) ? c_ADD_LAST : c_MUL_LAST;
    w_ph_en   = (r_state == ST_MUL) || (r_state == ST_ADD);
  end

  // State, registered Moore outputs, iteration count and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_iter     <= '0;
      r_timeout  <= 1'b0;
      r_all_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next);
      if (w_next == ST_INIT) begin
        r_iter     <= '0;
        r_timeout  <= 1'b0;
        r_all_zero <= 1'b0;
      end else if (r_state == ST_UPDATE) begin
        if (r_iter != c_ITER_SAT) begin
          r_iter <= r_iter + ITER_W'(1);
        end
        r_timeout  <= w_term_to;
        r_all_zero <= w_term_az;
      end
    end
  end

  assign load_x       = r_ctrl.load_x;
  assign load_t       = r_ctrl.load_t;
  assign select_t     = r_ctrl.select_t;
  assign mul_en       = r_ctrl.mul_en;
  assign add_en       = r_ctrl.add_en;
  assign busy         = r_ctrl.busy;
  assign result_valid = r_ctrl.result_valid;
  assign timeout      = r_timeout;
  assign all_zero     = r_all_zero;
  assign iter_cnt     = r_iter;

endmodule : maxnet_sequencer
`default_nettype wire

// File: tb/tb_maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxnet_sequencer
// Purpose  : Self-checking bench. dut0 uses default parameters, dut1 uses
//            MUL_CYCLES=3, ADD_CYCLES=2, MAX_ITER=4. A run-level reference
//            model tracks both; a vector table and directed sequences cover
//            the corner cases, then random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxnet_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[2], start_v[2], done_v[2], ack_v[2];
  logic [3:0] mask_v[2];
  logic       lx[2], lt[2], st[2], me[2], ae[2], bz[2], rv[2], to[2], az[2];
  logic [3:0] it0;
  logic [2:0] it1;

  maxnet_sequencer u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .done(done_v[0]),
    .active_mask(mask_v[0]), .result_ack(ack_v[0]),
    .load_x(lx[0]), .load_t(lt[0]), .select_t(st[0]), .mul_en(me[0]),
    .add_en(ae[0]), .busy(bz[0]), .result_valid(rv[0]), .timeout(to[0]),
    .all_zero(az[0]), .iter_cnt(it0)
  );

  maxnet_sequencer #(
    .N_NEURONS(4), .MUL_CYCLES(3), .ADD_CYCLES(2), .MAX_ITER(4)
  ) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .done(done_v[1]),
    .active_mask(mask_v[1]), .result_ack(ack_v[1]),
    .load_x(lx[1]), .load_t(lt[1]), .select_t(st[1]), .mul_en(me[1]),
    .add_en(ae[1]), .busy(bz[1]), .result_valid(rv[1]), .timeout(to[1]),
    .all_zero(az[1]), .iter_cnt(it1)
  );

  // ---------------- reference model (run-level view) ----------------
  // mode: 0 idle, 1 init, 2 iterating, 3 result held.
  // pos : cycle index within an iteration, 0..MUL+ADD (last = update).
  int P_MUL[2] = '{1, 3};
  int P_ADD[2] = '{1, 2};
  int P_MAX[2] = '{15, 4};
  int m_mode[2], m_pos[2], m_iter[2];
  bit m_to[2], m_az[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    int old;
    if (rst_v[k]) begin
      m_mode[k] = 0; m_pos[k] = 0; m_iter[k] = 0; m_to[k] = 0; m_az[k] = 0;
    end else begin
      case (m_mode[k])
        0: if (start_v[k]) begin
             m_mode[k] = 1; m_iter[k] = 0; m_to[k] = 0; m_az[k] = 0;
           end
        1: if (!start_v[k]) begin m_mode[k] = 2; m_pos[k] = 0; end
        2: begin
          if (m_pos[k] == P_MUL[k] + P_ADD[k]) begin
            old = m_iter[k];
            m_iter[k] = (old < P_MAX[k]) ? old + 1 : old;
            m_pos[k] = 0;
            if (done_v[k]) m_mode[k] = 3;
            else if (mask_v[k] == 4'd0) begin m_mode[k] = 3; m_az[k] = 1; end
            else if (old == P_MAX[k] - 1) begin m_mode[k] = 3; m_to[k] = 1; end
          end else begin
            m_pos[k]++;
          end
        end
        default: if (ack_v[k]) m_mode[k] = 0;
      endcase
    end
  endtask

  // Bit order: {load_x, load_t, select_t, mul_en, add_en, busy, valid, timeout, all_zero}
  function automatic logic [8:0] model_vec(input int k);
    logic [8:0] v;
    v = '0;
    case (m_mode[k])
      1: v[8:3] = 6'b111001;
      2: begin
        v[3] = 1'b1;
        if (m_pos[k] < P_MUL[k]) v[5] = 1'b1;
        else if (m_pos[k] < P_MUL[k] + P_ADD[k]) v[4] = 1'b1;
        else v[7] = 1'b1;
      end
      3: begin v[3] = 1'b1; v[2] = 1'b1; end
      default: v = '0;
    endcase
    v[1] = m_to[k];
    v[0] = m_az[k];
    return v;
  endfunction

  function automatic logic [8:0] dut_vec(input int k);
    return {lx[k], lt[k], st[k], me[k], ae[k], bz[k], rv[k], to[k], az[k]};
  endfunction

  function automatic int dut_iter(input int k);
    return (k == 0) ? int'(it0) : int'(it1);
  endfunction

  // One clock: advance model with the inputs in force at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    check("dut0_outputs_vs_model", int'(dut_vec(0)), int'(model_vec(0)));
    check("dut0_iter_vs_model", dut_iter(0), m_iter[0]);
    check("dut1_outputs_vs_model", int'(dut_vec(1)), int'(model_vec(1)));
    check("dut1_iter_vs_model", dut_iter(1), m_iter[1]);
  endtask

  task automatic set_in(input int k, input logic r, input logic s, input logic d,
                        input logic a, input logic [3:0] m);
    rst_v[k] = r; start_v[k] = s; done_v[k] = d; ack_v[k] = a; mask_v[k] = m;
  endtask

  // ---------------- vector table for dut0 (defaults) ----------------
  typedef struct {
    logic       r, s, d, a;
    logic [3:0] m;
    logic [8:0] exp;
    int         exp_iter;
  } vec_t;

  localparam logic [8:0] V_IDLE = 9'b000000000;
  localparam logic [8:0] V_INIT = 9'b111001000;
  localparam logic [8:0] V_MUL  = 9'b000101000;
  localparam logic [8:0] V_ADD  = 9'b000011000;
  localparam logic [8:0] V_UPD  = 9'b010001000;
  localparam logic [8:0] V_DONE = 9'b000001100;
  localparam logic [8:0] V_DAZ  = 9'b000001101;
  localparam logic [8:0] V_IAZ  = 9'b000000001;

  vec_t tbl[28];

  int n_upd, run_m, run_a, mn_m, mx_m, mn_a, mx_a, guard, c_init, c_done;

  initial begin
    for (int k = 0; k < 2; k++) begin
      set_in(k, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
      m_mode[k] = 0; m_pos[k] = 0; m_iter[k] = 0; m_to[k] = 0; m_az[k] = 0;
    end

    tbl[0]  = '{1,0,0,0,4'hF, V_IDLE, 0};
    tbl[1]  = '{1,0,0,0,4'hF, V_IDLE, 0};
    tbl[2]  = '{0,0,0,0,4'hF, V_IDLE, 0};
    tbl[3]  = '{0,1,0,0,4'hF, V_INIT, 0};
    tbl[4]  = '{0,0,1,0,4'hF, V_MUL,  0};
    tbl[5]  = '{0,0,1,0,4'hF, V_ADD,  0};
    tbl[6]  = '{0,0,0,0,4'hF, V_UPD,  0};
    tbl[7]  = '{0,0,1,0,4'hF, V_DONE, 1};
    tbl[8]  = '{0,1,0,0,4'hF, V_DONE, 1};
    tbl[9]  = '{0,0,0,0,4'hF, V_DONE, 1};
    tbl[10] = '{0,0,0,0,4'hF, V_DONE, 1};
    tbl[11] = '{0,0,0,1,4'hF, V_IDLE, 1};
    tbl[12] = '{0,0,0,1,4'hF, V_IDLE, 1};
    tbl[13] = '{0,1,0,0,4'hF, V_INIT, 0};
    tbl[14] = '{0,1,0,0,4'hF, V_INIT, 0};
    tbl[15] = '{0,1,0,0,4'hF, V_INIT, 0};
    tbl[16] = '{0,0,0,0,4'hF, V_MUL,  0};
    tbl[17] = '{0,0,0,0,4'hF, V_ADD,  0};
    tbl[18] = '{0,0,0,0,4'h0, V_UPD,  0};
    tbl[19] = '{0,0,0,0,4'h0, V_DAZ,  1};
    tbl[20] = '{0,0,0,1,4'h0, V_IAZ,  1};
    tbl[21] = '{1,0,0,0,4'hF, V_IDLE, 0};
    tbl[22] = '{0,1,0,0,4'hF, V_INIT, 0};
    tbl[23] = '{0,0,0,0,4'hF, V_MUL,  0};
    tbl[24] = '{0,0,0,0,4'h0, V_ADD,  0};
    tbl[25] = '{0,0,0,0,4'h0, V_UPD,  0};
    tbl[26] = '{0,0,1,0,4'h0, V_DONE, 1};
    tbl[27] = '{0,0,0,1,4'hF, V_IDLE, 1};

    for (int i = 0; i < 28; i++) begin
      set_in(0, tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].a, tbl[i].m);
      tick();
      check("table_outputs", int'(dut_vec(0)), int'(tbl[i].exp));
      check("table_iter", dut_iter(0), tbl[i].exp_iter);
    end

    // Reset then idle for 10 cycles with start low.
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    tick(); tick();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hold", int'(dut_vec(0)), 0);
    end

    // dut1: timeout run, done never asserted, mask 0011.
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
    tick();
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
    n_upd = 0; run_m = 0; run_a = 0; mn_m = 999; mx_m = 0; mn_a = 999; mx_a = 0; guard = 0;
    while (!rv[1] && guard < 200) begin
      tick();
      guard++;
      if (lt[1] && !st[1]) n_upd++;
      if (me[1]) run_m++;
      else if (run_m != 0) begin
        if (run_m < mn_m) mn_m = run_m;
        if (run_m > mx_m) mx_m = run_m;
        run_m = 0;
      end
      if (ae[1]) run_a++;
      else if (run_a != 0) begin
        if (run_a < mn_a) mn_a = run_a;
        if (run_a > mx_a) mx_a = run_a;
        run_a = 0;
      end
    end
    check("timeout_run_finished", int'(guard < 200), 1);
    check("timeout_update_pulses", n_upd, 4);
    check("mul_run_min", mn_m, 3);
    check("mul_run_max", mx_m, 3);
    check("add_run_min", mn_a, 2);
    check("add_run_max", mx_a, 2);
    check("timeout_flag", int'(to[1]), 1);
    check("timeout_all_zero", int'(az[1]), 0);
    check("timeout_iter", int'(it1), 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold_no_ack", int'(rv[1]), 1);
    end
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
    tick();
    check("ack_release", int'(rv[1]), 0);

    // dut1: done coincides with the iteration limit -> timeout stays low.
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
    tick();
    start_v[1] = 1'b0; ack_v[1] = 1'b0;
    guard = 0;
    while (!rv[1] && guard < 200) begin
      done_v[1] = (m_mode[1] == 2) && (m_pos[1] == P_MUL[1] + P_ADD[1]) && (m_iter[1] == 3);
      tick();
      guard++;
    end
    check("done_at_limit_finished", int'(guard < 200), 1);
    check("done_at_limit_timeout", int'(to[1]), 0);
    check("done_at_limit_iter", int'(it1), 4);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
    tick();

    // dut1: done on the 3rd UPDATE, latency from INIT.
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
    tick();
    c_init = cyc;
    check("init_seen", int'(st[1]), 1);
    start_v[1] = 1'b0;
    guard = 0;
    while (!rv[1] && guard < 200) begin
      done_v[1] = (m_mode[1] == 2) && (m_pos[1] == P_MUL[1] + P_ADD[1]) && (m_iter[1] == 2);
      tick();
      guard++;
    end
    c_done = cyc;
    check("third_update_latency", c_done - c_init, 1 + 3 * 6);
    check("third_update_iter", int'(it1), 3);
    check("third_update_timeout", int'(to[1]), 0);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111);
    tick();

    // dut1: reset during ADD of the second iteration, then a fresh run.
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
    tick();
    start_v[1] = 1'b0;
    guard = 0;
    while (!(m_mode[1] == 2 && m_iter[1] == 1 && m_pos[1] == P_MUL[1]) && guard < 200) begin
      tick();
      guard++;
    end
    check("reach_iter2_add", int'(ae[1]), 1);
    rst_v[1] = 1'b1;
    tick();
    check("mid_run_reset_outputs", int'(dut_vec(1)), 0);
    check("mid_run_reset_iter", int'(it1), 0);
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
    tick();
    set_in(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0111);
    guard = 0;
    while (!rv[1] && guard < 200) begin
      tick();
      guard++;
    end
    check("fresh_run_iter", int'(it1), 1);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111);
    tick();

    // Random stimulus on both instances against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k]   = ($urandom_range(0, 199) == 0);
        start_v[k] = ($urandom_range(0, 3) == 0);
        done_v[k]  = ($urandom_range(0, 5) == 0);
        ack_v[k]   = ($urandom_range(0, 2) == 0);
        mask_v[k]  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_maxnet_sequencer
`default_nettype wire
